mult_div_unit: RTL

- Execute-stage HI/LO multiply/divide unit.
- Responder to the decoder's `start`, `mdop`, `mdwe`, `hilo` and `fhilo` controls.
- Returns `busy` to the hazard unit, which stalls any mult/div-class instruction in decode while `busy`=1.
- Holds the architectural HI/LO registers and drives the value read by mfhi/mflo.

---
 rtl/mult_div_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Execute-stage HI/LO multiply/divide unit. Launches a fixed-latency
//   mult/multu/div/divu on a start pulse, commits the result into HI/LO on
//   the last busy cycle, and supports direct HI/LO writes (mthi/mtlo).
//
// Parameters
//   MULT_CYCLES   busy cycles after launch for mult/multu (1..15)
//   DIV_CYCLES    busy cycles after launch for div/divu   (1..15)
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset, clears HI/LO and counter
//   start      launch pulse, operation selected by mdop
//   mdop       00 multu, 01 mult, 10 divu, 11 div
//   mdwe       direct HI/LO write when idle and not starting
//   hilo       mdwe target: 1 HI, 0 LO
//   fhilo      read select: 1 HI, 0 LO
//   rs_data    operand A / dividend / mdwe source
//   rt_data    operand B / divisor
//   busy       start | operation pending (combinational)
//   hilo_out   fhilo ? HI : LO (combinational, committed values only)
//   cancel     squash a running operation (only with MDU_CANCEL_EN)
//
// Build option
//   MDU_CANCEL_EN  adds the cancel input
//
// States (derived from the counter)
//   state | meaning
//   IDLE  | cnt == 0, accepts start or mdwe
//   RUN   | cnt != 0, counting down; result commits on the 1 -> 0 edge
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mdop,
    input  logic        mdwe,
    input  logic        hilo,
    input  logic        fhilo,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hilo_out
`ifdef MDU_CANCEL_EN
    ,
    input  logic        cancel
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [3:0]  r_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    state_t      w_state;
    logic        w_cancel;
    logic [63:0] w_prod_u;
    logic signed [63:0] w_prod_s;
    logic        w_signed;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_div_q;
    logic [31:0] w_div_r;

`ifdef MDU_CANCEL_EN
    assign w_cancel = cancel;
`else
    assign w_cancel = 1'b0;
`endif

    assign w_state  = (r_cnt != 4'd0) ? RUN : IDLE;
    assign busy     = start | (r_cnt != 4'd0);
    assign hilo_out = fhilo ? r_hi : r_lo;

    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});

    // Signed division via magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend. 0x80000000 / -1 falls out naturally as
    // quotient 0x80000000, remainder 0, with no host-side overflow.
    assign w_signed = r_op[0];
    assign w_mag_a  = (w_signed && r_a[31]) ? (32'd0 - r_a) : r_a;
    assign w_mag_b  = (w_signed && r_b[31]) ? (32'd0 - r_b) : r_b;
    assign w_q_mag  = (w_mag_b != 32'd0) ? (w_mag_a / w_mag_b) : 32'd0;
    assign w_r_mag  = (w_mag_b != 32'd0) ? (w_mag_a % w_mag_b) : 32'd0;
    assign w_div_q  = (w_signed && (r_a[31] ^ r_b[31])) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_div_r  = (w_signed && r_a[31]) ? (32'd0 - w_r_mag) : w_r_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
            r_cnt <= 4'd0;
            r_op  <= 2'd0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
        end else begin
            case (w_state)
                IDLE: begin
                    if (start && !w_cancel) begin
                        r_op  <= mdop;
                        r_a   <= rs_data;
                        r_b   <= rt_data;
                        r_cnt <= mdop[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    end else if (mdwe && !start) begin
                        if (hilo) r_hi <= rs_data;
                        else      r_lo <= rs_data;
                    end
                end
                RUN: begin
                    if (w_cancel) begin
                        r_cnt <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            if (!r_op[1]) begin
                                if (r_op[0]) begin
                                    r_hi <= w_prod_s[63:32];
                                    r_lo <= w_prod_s[31:0];
                                end else begin
                                    r_hi <= w_prod_u[63:32];
                                    r_lo <= w_prod_u[31:0];
                                end
                            end else if (r_b != 32'd0) begin
                                r_hi <= w_div_r;
                                r_lo <= w_div_q;
                            end
                        end
                    end
                end
                default: r_cnt <= 4'd0;
            endcase
        end
    end

endmodule
